pipeline_hazard_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 3-stage pipeline (F -> DE -> MW).

---
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the F -> DE -> MW pipeline: forwarding,
// load-use bubbles, branch flushes, data-memory freeze with timeout, stall counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_E,
    input  logic [4:0]       rs2_E,
    input  logic             use_rs1_E,
    input  logic             use_rs2_E,
    input  logic             br_taken_E,
    input  logic [4:0]       waddr_MW,
    input  logic             reg_wr_MW,
    input  logic             is_load_MW,
    input  logic             mem_req_MW,
    input  logic             mem_ready,
    output logic             en_PC,
    output logic             en_FD,
    output logic             clr_FD,
    output logic             en_MW,
    output logic             clr_MW,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        ERR_FLUSH = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;

    logic hit_a, hit_b, mem_busy, load_use;
    logic fwd_ok_a, fwd_ok_b;

    // x0 is hard-wired zero, so a write to it is never a dependency
    assign hit_a    = reg_wr_MW && (waddr_MW != 5'd0) && (waddr_MW == rs1_E) && use_rs1_E;
    assign hit_b    = reg_wr_MW && (waddr_MW != 5'd0) && (waddr_MW == rs2_E) && use_rs2_E;
    assign fwd_ok_a = hit_a && !is_load_MW;
    assign fwd_ok_b = hit_b && !is_load_MW;
    assign mem_busy = mem_req_MW && !mem_ready;
    assign load_use = is_load_MW && (hit_a || hit_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (!en_PC && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        en_PC     = 1'b1;
        en_FD     = 1'b1;
        en_MW     = 1'b1;
        clr_FD    = 1'b0;
        clr_MW    = 1'b0;
        fwd_a     = 1'b0;
        fwd_b     = 1'b0;
        mem_err   = 1'b0;

        case (state)
            RUN: begin
                fwd_a = fwd_ok_a;
                fwd_b = fwd_ok_b;
                if (mem_busy) begin
                    en_PC     = 1'b0;
                    en_FD     = 1'b0;
                    en_MW     = 1'b0;
                    wait_nxt  = WAIT_W'(1);
                    state_nxt = MEM_WAIT;
                end else if (load_use) begin
                    // stale operands this cycle, so a taken branch is deferred
                    en_PC  = 1'b0;
                    en_FD  = 1'b0;
                    clr_MW = 1'b1;
                end else if (br_taken_E) begin
                    clr_FD = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    // access completes: issue decision happens in this same cycle
                    fwd_a     = fwd_ok_a;
                    fwd_b     = fwd_ok_b;
                    wait_nxt  = '0;
                    state_nxt = RUN;
                    if (load_use) begin
                        en_PC  = 1'b0;
                        en_FD  = 1'b0;
                        clr_MW = 1'b1;
                    end else if (br_taken_E) begin
                        clr_FD = 1'b1;
                    end
                end else begin
                    en_PC = 1'b0;
                    en_FD = 1'b0;
                    en_MW = 1'b0;
                    if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                        mem_err   = 1'b1;
                        wait_nxt  = '0;
                        state_nxt = ERR_FLUSH;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
            end
            ERR_FLUSH: begin
                clr_FD    = 1'b1;
                clr_MW    = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase

        if (rst) begin
            en_PC   = 1'b1;
            en_FD   = 1'b1;
            en_MW   = 1'b1;
            clr_FD  = 1'b0;
            clr_MW  = 1'b0;
            fwd_a   = 1'b0;
            fwd_b   = 1'b0;
            mem_err = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by random traffic,
// all outputs compared every cycle against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned CNT_W    = 6;
    localparam int          SAT      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1_E, rs2_E, waddr_MW;
    logic use_rs1_E, use_rs2_E, br_taken_E, reg_wr_MW, is_load_MW, mem_req_MW, mem_ready;
    logic en_PC, en_FD, clr_FD, en_MW, clr_MW, fwd_a, fwd_b, mem_err;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    bit m_wait, m_flush;
    int m_waited, m_stall;
    bit e_en_pc, e_en_fd, e_en_mw, e_clr_fd, e_clr_mw, e_fwd_a, e_fwd_b, e_err;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_E(rs1_E), .rs2_E(rs2_E), .use_rs1_E(use_rs1_E), .use_rs2_E(use_rs2_E),
        .br_taken_E(br_taken_E), .waddr_MW(waddr_MW), .reg_wr_MW(reg_wr_MW),
        .is_load_MW(is_load_MW), .mem_req_MW(mem_req_MW), .mem_ready(mem_ready),
        .en_PC(en_PC), .en_FD(en_FD), .clr_FD(clr_FD), .en_MW(en_MW), .clr_MW(clr_MW),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input int s1, input int s2, input bit u1, input bit u2,
                         input bit br, input int wa, input bit wr, input bit ld,
                         input bit req, input bit rdy);
        rst = r; rs1_E = 5'(s1); rs2_E = 5'(s2); use_rs1_E = u1; use_rs2_E = u2;
        br_taken_E = br; waddr_MW = 5'(wa); reg_wr_MW = wr; is_load_MW = ld;
        mem_req_MW = req; mem_ready = rdy;
    endtask

    task automatic idle();
        drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Sample at the falling edge and compare everything against the model
    task automatic eval();
        bit ha, hb, frozen;
        @(negedge clk);
        ha = reg_wr_MW && waddr_MW != 0 && waddr_MW == rs1_E && use_rs1_E;
        hb = reg_wr_MW && waddr_MW != 0 && waddr_MW == rs2_E && use_rs2_E;
        {e_en_pc, e_en_fd, e_en_mw} = 3'b111;
        {e_clr_fd, e_clr_mw, e_fwd_a, e_fwd_b, e_err} = 5'b0;
        frozen = m_wait ? !mem_ready : (mem_req_MW && !mem_ready);
        if (!rst) begin
            if (m_flush) begin
                e_clr_fd = 1; e_clr_mw = 1;
            end else if (frozen) begin
                {e_en_pc, e_en_fd, e_en_mw} = 3'b000;
                if (!m_wait) begin
                    e_fwd_a = ha && !is_load_MW;
                    e_fwd_b = hb && !is_load_MW;
                end
                e_err = m_wait && (m_waited == MAX_WAIT);
            end else begin
                e_fwd_a = ha && !is_load_MW;
                e_fwd_b = hb && !is_load_MW;
                if (is_load_MW && (ha || hb)) begin
                    e_en_pc = 0; e_en_fd = 0; e_clr_mw = 1;
                end else if (br_taken_E) begin
                    e_clr_fd = 1;
                end
            end
        end
        chk("en_PC", 32'(en_PC), 32'(e_en_pc));
        chk("en_FD", 32'(en_FD), 32'(e_en_fd));
        chk("en_MW", 32'(en_MW), 32'(e_en_mw));
        chk("clr_FD", 32'(clr_FD), 32'(e_clr_fd));
        chk("clr_MW", 32'(clr_MW), 32'(e_clr_mw));
        chk("fwd_a", 32'(fwd_a), 32'(e_fwd_a));
        chk("fwd_b", 32'(fwd_b), 32'(e_fwd_b));
        chk("mem_err", 32'(mem_err), 32'(e_err));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    endtask

    // Advance the model across the rising edge using the inputs held there
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_wait = 0; m_flush = 0; m_waited = 0; m_stall = 0;
        end else begin
            if (!e_en_pc && m_stall < SAT) m_stall++;
            if (m_flush) begin
                m_flush = 0;
            end else if (m_wait) begin
                if (mem_ready) begin
                    m_wait = 0; m_waited = 0;
                end else if (m_waited == MAX_WAIT) begin
                    m_wait = 0; m_waited = 0; m_flush = 1;
                end else begin
                    m_waited++;
                end
            end else if (mem_req_MW && !mem_ready) begin
                m_wait = 1; m_waited = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        eval(); tick();
        idle();
    endtask

    initial begin
        m_wait = 0; m_flush = 0; m_waited = 0; m_stall = 0;
        // reset with hazardous inputs: everything enabled, nothing cleared
        drive(1, 7, 7, 1, 1, 1, 7, 1, 1, 1, 0);
        eval(); chk("rst_en_PC", 32'(en_PC), 32'd1); chk("rst_clr_MW", 32'(clr_MW), 32'd0);
        tick(); eval(); tick();
        idle();
        eval(); chk("post_rst_stall", 32'(stall_cnt), 32'd0); tick();

        // ALU result forwarding on rs1 only
        drive(0, 5, 3, 1, 1, 0, 5, 1, 0, 0, 1);
        eval(); chk("fwd5_a", 32'(fwd_a), 32'd1); chk("fwd5_b", 32'(fwd_b), 32'd0);
        chk("fwd5_en_PC", 32'(en_PC), 32'd1); tick();

        // x0 never forwarded
        drive(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1);
        eval(); chk("x0_fwd_a", 32'(fwd_a), 32'd0); tick();

        // load-use with simultaneous taken branch
        do_reset();
        drive(0, 1, 7, 1, 1, 1, 7, 1, 1, 0, 1);
        eval(); chk("lu_en_PC", 32'(en_PC), 32'd0); chk("lu_clr_MW", 32'(clr_MW), 32'd1);
        chk("lu_clr_FD", 32'(clr_FD), 32'd0); tick();
        idle();
        eval(); chk("lu_resume", 32'({en_PC, en_FD, en_MW}), 32'b111);
        chk("lu_stall", 32'(stall_cnt), 32'd1); tick();

        // three-cycle memory wait then completion
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0);
            eval(); chk("mw_frozen", 32'(en_PC), 32'd0); chk("mw_err", 32'(mem_err), 32'd0); tick();
        end
        drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1);
        eval(); chk("mw_done_en", 32'(en_PC), 32'd1); tick();
        idle();
        eval(); chk("mw_stall", 32'(stall_cnt), 32'd3); tick();

        // timeout: mem_err pulse, one flush cycle, back to run
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0);
            eval(); chk("to_err", 32'(mem_err), (k == 4) ? 32'd1 : 32'd0); tick();
        end
        eval(); chk("to_flush", 32'({clr_FD, clr_MW, en_PC}), 32'b111); tick();
        idle();
        eval(); chk("to_run", 32'({clr_FD, clr_MW, en_PC}), 32'b001); tick();

        // reset in the middle of a memory wait
        do_reset();
        drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0);
        eval(); tick(); eval(); tick();
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0);
        eval(); chk("rstw_err", 32'(mem_err), 32'd0); tick();
        idle();
        eval(); chk("rstw_stall", 32'(stall_cnt), 32'd0); chk("rstw_en", 32'(en_PC), 32'd1); tick();

        // stall counter saturation
        for (int k = 0; k < 80; k++) begin
            drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0);
            eval(); tick();
        end
        idle();
        eval(); chk("sat_stall", 32'(stall_cnt), 32'(SAT)); tick();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0,
                  (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0));
            eval(); tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
